elastic_stage_reg: RTL and testbench
====================================

// Module: elastic_stage_reg
// PURPOSE
// - Generalised pipeline stage register placed between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Replaces clear/hold control with a valid/ready handshake.
// - Carries an opaque payload plus a register-forwarding sideband, and exports the forwarding port of the entry it currently holds.
// - MODE selects one of two implementations:
//   - SKID: two entries, full throughput, registered in_ready.
//   - PLAIN: one entry, combinational ready.
// PARAMETERS
// - DATA_W  32  payload width in bits (struct packed into a vector by the instantiating stage)
// - ADDR_W  5   forwarding destination register address width
// - VAL_W   32  forwarding value width
// - MODE    0   0 = SKID (2 entries), 1 = PLAIN (1 entry)
// PORTS
// - clock         in   1       clock; all state updates on posedge clock
// - reset         in   1       reset; synchronous, active-high
// - flush         in   1       synchronous kill of all held entries (branch/exception)
// - in_valid      in   1       upstream offers an entry
// - in_ready      out  1       stage can accept an entry this cycle
// - in_data       in   DATA_W  payload
// - in_fwd_write  in   1       entry will write the register file
// - in_fwd_eval   in   1       in_fwd_value is already final
// - in_fwd_addr   in   ADDR_W  destination register
// - in_fwd_value  in   VAL_W   forwarding value
// - out_valid     out  1       head entry valid
// - out_ready     in   1       downstream consumes the head entry
// - out_data      out  DATA_W  head payload
// - fwd_write     out  1       head fwd_write AND out_valid
// - fwd_eval      out  1       head fwd_eval AND out_valid
// - fwd_addr      out  ADDR_W  head destination register
// - fwd_value     out  VAL_W   head forwarding value
// BEHAVIOUR
// - Handshakes:
//   - in_fire = in_valid & in_ready.
//   - out_fire = out_valid & out_ready.
//   - Data, once offered, is never dropped or duplicated, except on flush.
// - Reset (and flush) result: all valid bits = 0, all data/sideband registers = 0, state EMPTY.
//   - Consequently out_valid = 0, fwd_write = 0, fwd_eval = 0, fwd_addr = 0, fwd_value = 0, out_data = 0.
//   - in_ready = 1 in SKID mode.
// - Inputs presented during the reset cycle are ignored.
// - SKID mode, states EMPTY / ONE / TWO. A main register holds the head entry; a skid register holds the overflow entry.
//   - in_ready = ~skid_valid, a pure register output with no comb path from out_ready.
//   - EMPTY: in_fire -> ONE (main <= in).
//   - ONE:
//     - in_fire & out_fire -> ONE (main <= in).
//     - in_fire & ~out_fire -> TWO (skid <= in).
//     - out_fire only -> EMPTY.
//   - TWO: in_ready = 0.
//     - out_fire -> ONE (main <= skid, skid cleared).
//     - Otherwise hold.
//   - Latency 1 cycle, EMPTY to out_valid. Sustained throughput 1 entry/cycle while out_ready = 1.
// - PLAIN mode: single main register.
//   - in_ready = ~out_valid | out_ready (combinational).
//   - in_fire loads main; out_fire without in_fire clears valid.
//   - Latency 1 cycle.
// - Flush:
//   - Highest priority after reset.
//   - Next state is EMPTY regardless of in_fire/out_fire in the same cycle; an entry accepted in the flush cycle is discarded.
//   - The out_fire in the flush cycle still completes downstream.
// - Forward port:
//   - Reflects the head entry only; the skid entry is never forwarded because it is younger than the head.
//   - fwd_write and fwd_eval are gated by out_valid, so an empty stage never forwards.
//   - fwd_addr/fwd_value are driven from the head entry registers, which read 0 after reset or flush.
// - Simultaneous events, priority order: reset > flush > (in_fire, out_fire) per the state table.
// - Data registers update only on the load conditions above. No update on idle cycles (low power, stable debug view).
// - Simulation-only assertions:
//   - in_valid held with in_data stable until in_fire.
//   - No in_fire in state TWO.
// STRUCTURE
// - Shared package pipe_pkg:
//   - typedef struct packed ForwardEntry {write, eval, addr, value}.
//   - localparams MODE_SKID = 0, MODE_PLAIN = 1.
//   - typedef enum logic [1:0] StageState {EMPTY, ONE, TWO}.
// - One sub-module stage_slot (valid bit + payload + ForwardEntry register with load/clear), instantiated as main and skid.
// - The skid instance is generated only when MODE == MODE_SKID.
// TESTING
// - Reset: hold reset 2 cycles with in_valid = 1 -> out_valid = 0, fwd_write = 0, out_data = 0; in_ready = 1 (SKID) the cycle after release.
// - Streaming: out_ready = 1, feed payloads 1..8 back to back -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
// - Backpressure: SKID mode, out_ready = 0 after 3 accepts -> in_ready = 0 after 2nd entry held; raise out_ready -> order 1,2,3 preserved, no loss.
// - Flush: state TWO with entries 0xA, 0xB, assert flush with in_valid = 1 (0xC) -> next cycle out_valid = 0, state EMPTY, 0xC never appears.
// - Forwarding: head entry write = 1, eval = 1, addr = 5, value = 0x1234 with out_ready = 0 -> fwd_addr = 5, fwd_value = 0x1234 every cycle; after out_fire with empty input -> fwd_write = 0.
// - PLAIN mode: out_valid = 1, out_ready = 1, in_valid = 1 same cycle -> in_ready = 1 combinationally, new entry replaces head with no bubble.

Source files
------------

// File: rtl/elastic_stage_reg_pkg.sv
// Shared pipeline-stage types: stage implementation modes, handshake FSM states
// and the forwarding sideband record used by default-width stages.
package pipe_pkg;

    localparam int MODE_SKID  = 0;
    localparam int MODE_PLAIN = 1;

    localparam int FWD_ADDR_W = 5;
    localparam int FWD_VAL_W  = 32;

    typedef struct packed {
        logic                  write;
        logic                  eval;
        logic [FWD_ADDR_W-1:0] addr;
        logic [FWD_VAL_W-1:0]  value;
    } ForwardEntry;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } StageState;

endpackage

// File: rtl/elastic_stage_reg_slot.sv
// One stage entry: valid bit, payload and forwarding sideband with load/drop/clear.
// clear zeroes everything; drop only invalidates, keeping the data view stable.
module stage_slot #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int VAL_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              drop,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_write,
    input  logic              load_eval,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [VAL_W-1:0]  load_value,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              fwd_write,
    output logic              fwd_eval,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [VAL_W-1:0]  fwd_value
);

    typedef struct packed {
        logic              write;
        logic              eval;
        logic [ADDR_W-1:0] addr;
        logic [VAL_W-1:0]  value;
    } slot_fwd_t;

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    slot_fwd_t         fwd_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            fwd_q   <= '0;
        end else if (load) begin
            valid_q     <= 1'b1;
            data_q      <= load_data;
            fwd_q.write <= load_write;
            fwd_q.eval  <= load_eval;
            fwd_q.addr  <= load_addr;
            fwd_q.value <= load_value;
        end else if (drop) begin
            valid_q <= 1'b0;
        end
    end

    assign valid     = valid_q;
    assign data      = data_q;
    assign fwd_write = fwd_q.write;
    assign fwd_eval  = fwd_q.eval;
    assign fwd_addr  = fwd_q.addr;
    assign fwd_value = fwd_q.value;

endmodule

// File: rtl/elastic_stage_reg.sv
// Valid/ready pipeline stage register with forwarding export of the head entry.
// MODE_SKID: main + skid entries, registered in_ready; MODE_PLAIN: one entry.
module elastic_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int VAL_W  = 32,
    parameter int MODE   = MODE_SKID
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_fwd_write,
    input  logic              in_fwd_eval,
    input  logic [ADDR_W-1:0] in_fwd_addr,
    input  logic [VAL_W-1:0]  in_fwd_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              fwd_write,
    output logic              fwd_eval,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [VAL_W-1:0]  fwd_value
);

    StageState state_q, state_d;

    logic in_fire, out_fire;
    logic main_load, main_drop, main_from_skid, skid_load, skid_clear;

    logic              main_valid, main_write, main_eval;
    logic [DATA_W-1:0] main_data;
    logic [ADDR_W-1:0] main_addr;
    logic [VAL_W-1:0]  main_value;

    logic              skid_valid, skid_write, skid_eval;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_addr;
    logic [VAL_W-1:0]  skid_value;

    logic              ld_write, ld_eval;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] ld_addr;
    logic [VAL_W-1:0]  ld_value;

    assign in_ready = (MODE == MODE_SKID) ? ~skid_valid : (~main_valid | out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_drop      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = flush;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire && MODE == MODE_SKID) begin
                    skid_load = 1'b1;
                    state_d   = TWO;
                end else if (out_fire) begin
                    main_drop = 1'b1;
                    state_d   = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Slots give clear priority over load, so flush discards same-cycle accepts.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        ld_data  = in_data;
        ld_write = in_fwd_write;
        ld_eval  = in_fwd_eval;
        ld_addr  = in_fwd_addr;
        ld_value = in_fwd_value;
        if (main_from_skid) begin
            ld_data  = skid_data;
            ld_write = skid_write;
            ld_eval  = skid_eval;
            ld_addr  = skid_addr;
            ld_value = skid_value;
        end
    end

    stage_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VAL_W(VAL_W)) u_main (
        .clock      (clock),
        .reset      (reset),
        .clear      (flush),
        .load       (main_load),
        .drop       (main_drop),
        .load_data  (ld_data),
        .load_write (ld_write),
        .load_eval  (ld_eval),
        .load_addr  (ld_addr),
        .load_value (ld_value),
        .valid      (main_valid),
        .data       (main_data),
        .fwd_write  (main_write),
        .fwd_eval   (main_eval),
        .fwd_addr   (main_addr),
        .fwd_value  (main_value)
    );

    if (MODE == MODE_SKID) begin : g_skid
        stage_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VAL_W(VAL_W)) u_skid (
            .clock      (clock),
            .reset      (reset),
            .clear      (skid_clear),
            .load       (skid_load),
            .drop       (1'b0),
            .load_data  (in_data),
            .load_write (in_fwd_write),
            .load_eval  (in_fwd_eval),
            .load_addr  (in_fwd_addr),
            .load_value (in_fwd_value),
            .valid      (skid_valid),
            .data       (skid_data),
            .fwd_write  (skid_write),
            .fwd_eval   (skid_eval),
            .fwd_addr   (skid_addr),
            .fwd_value  (skid_value)
        );
    end else begin : g_no_skid
        assign skid_valid = 1'b0;
        assign skid_data  = '0;
        assign skid_write = 1'b0;
        assign skid_eval  = 1'b0;
        assign skid_addr  = '0;
        assign skid_value = '0;
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign fwd_write = main_write & main_valid;
    assign fwd_eval  = main_eval & main_valid;
    assign fwd_addr  = main_addr;
    assign fwd_value = main_value;

    // Upstream protocol watch: a stalled offer must stay put until accepted.
    logic              pend_q;
    logic [DATA_W-1:0] pend_data_q;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= in_valid & ~in_ready;
        end
        pend_data_q <= in_data;
        if (!reset && !flush && pend_q) begin
            a_offer_held: assert (in_valid && in_data == pend_data_q);
        end
        if (!reset) begin
            a_no_fire_in_two: assert (!(state_q == TWO && in_fire));
        end
    end

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Directed bench for elastic_stage_reg: a SKID instance and a PLAIN instance
// driven in sequence with hand-computed expectations.
module tb_elastic_stage_reg;
    import pipe_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        s_flush, s_in_valid, s_in_ready, s_in_write, s_in_eval;
    logic [31:0] s_in_data, s_in_value, s_out_data, s_fwd_value;
    logic [4:0]  s_in_addr, s_fwd_addr;
    logic        s_out_valid, s_out_ready, s_fwd_write, s_fwd_eval;

    logic        p_flush, p_in_valid, p_in_ready, p_in_write, p_in_eval;
    logic [31:0] p_in_data, p_in_value, p_out_data, p_fwd_value;
    logic [4:0]  p_in_addr, p_fwd_addr;
    logic        p_out_valid, p_out_ready, p_fwd_write, p_fwd_eval;

    int checks = 0;
    int errors = 0;

    elastic_stage_reg #(.DATA_W(32), .ADDR_W(5), .VAL_W(32), .MODE(MODE_SKID)) u_skid (
        .clock(clock), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_fwd_write(s_in_write), .in_fwd_eval(s_in_eval),
        .in_fwd_addr(s_in_addr), .in_fwd_value(s_in_value),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .fwd_write(s_fwd_write), .fwd_eval(s_fwd_eval),
        .fwd_addr(s_fwd_addr), .fwd_value(s_fwd_value)
    );

    elastic_stage_reg #(.DATA_W(32), .ADDR_W(5), .VAL_W(32), .MODE(MODE_PLAIN)) u_plain (
        .clock(clock), .reset(reset), .flush(p_flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
        .in_fwd_write(p_in_write), .in_fwd_eval(p_in_eval),
        .in_fwd_addr(p_in_addr), .in_fwd_value(p_in_value),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .fwd_write(p_fwd_write), .fwd_eval(p_fwd_eval),
        .fwd_addr(p_fwd_addr), .fwd_value(p_fwd_value)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b1; s_in_data = 32'h55; s_out_ready = 1'b0;
        s_in_write = 1'b0; s_in_eval = 1'b0; s_in_addr = 5'd0; s_in_value = 32'd0;
        p_flush = 1'b0; p_in_valid = 1'b1; p_in_data = 32'h66; p_out_ready = 1'b0;
        p_in_write = 1'b0; p_in_eval = 1'b0; p_in_addr = 5'd0; p_in_value = 32'd0;

        // reset held two cycles with offers present
        tick(); tick();
        check("rst_out_valid", 32'(s_out_valid), 32'd0);
        check("rst_fwd_write", 32'(s_fwd_write), 32'd0);
        check("rst_out_data", s_out_data, 32'd0);
        check("rst_plain_valid", 32'(p_out_valid), 32'd0);
        reset = 1'b0; s_in_valid = 1'b0; p_in_valid = 1'b0;
        tick();
        check("rst_in_ready", 32'(s_in_ready), 32'd1);
        check("rst_out_valid_after", 32'(s_out_valid), 32'd0);

        // streaming 1..8 with out_ready high
        s_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_in_valid = 1'b1; s_in_data = 32'(i);
            #1;
            check("stream_in_ready", 32'(s_in_ready), 32'd1);
            tick();
            check("stream_valid", 32'(s_out_valid), 32'd1);
            check("stream_data", s_out_data, 32'(i));
        end
        s_in_valid = 1'b0;
        tick();
        check("stream_drained", 32'(s_out_valid), 32'd0);

        // backpressure: 1 and 2 fill both entries, 3 waits
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'd1;
        tick();
        check("bp_ready_one", 32'(s_in_ready), 32'd1);
        s_in_data = 32'd2;
        tick();
        check("bp_ready_two", 32'(s_in_ready), 32'd0);
        check("bp_head_two", s_out_data, 32'd1);
        s_in_data = 32'd3;
        tick();
        check("bp_hold_ready", 32'(s_in_ready), 32'd0);
        check("bp_hold_head", s_out_data, 32'd1);
        s_out_ready = 1'b1;
        tick();
        check("bp_order_2", s_out_data, 32'd2);
        check("bp_ready_back", 32'(s_in_ready), 32'd1);
        tick();
        check("bp_order_3", s_out_data, 32'd3);
        check("bp_valid_3", 32'(s_out_valid), 32'd1);
        s_in_valid = 1'b0;
        tick();
        check("bp_empty", 32'(s_out_valid), 32'd0);

        // flush from TWO with a new offer in the flush cycle
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'hA;
        tick();
        s_in_data = 32'hB;
        tick();
        check("fl_full", 32'(s_in_ready), 32'd0);
        check("fl_head", s_out_data, 32'hA);
        s_flush = 1'b1; s_in_data = 32'hC;
        tick();
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        check("fl_out_valid", 32'(s_out_valid), 32'd0);
        check("fl_out_data", s_out_data, 32'd0);
        check("fl_in_ready", 32'(s_in_ready), 32'd1);
        tick();
        check("fl_no_c_1", 32'(s_out_valid), 32'd0);
        tick();
        check("fl_no_c_2", 32'(s_out_valid), 32'd0);

        // forwarding: head entry exported, skid entry hidden, empty stage silent
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'h77;
        s_in_write = 1'b1; s_in_eval = 1'b1; s_in_addr = 5'd5; s_in_value = 32'h1234;
        tick();
        s_in_valid = 1'b0;
        check("fw_addr", 32'(s_fwd_addr), 32'd5);
        check("fw_value", s_fwd_value, 32'h1234);
        check("fw_write", 32'(s_fwd_write), 32'd1);
        check("fw_eval", 32'(s_fwd_eval), 32'd1);
        tick();
        check("fw_addr_hold", 32'(s_fwd_addr), 32'd5);
        check("fw_value_hold", s_fwd_value, 32'h1234);
        s_in_valid = 1'b1; s_in_data = 32'h78;
        s_in_write = 1'b1; s_in_eval = 1'b0; s_in_addr = 5'd7; s_in_value = 32'h22;
        tick();
        s_in_valid = 1'b0;
        check("fw_skid_hidden_addr", 32'(s_fwd_addr), 32'd5);
        check("fw_skid_hidden_eval", 32'(s_fwd_eval), 32'd1);
        s_out_ready = 1'b1;
        tick();
        check("fw_second_addr", 32'(s_fwd_addr), 32'd7);
        check("fw_second_eval", 32'(s_fwd_eval), 32'd0);
        check("fw_second_data", s_out_data, 32'h78);
        tick();
        check("fw_empty_write", 32'(s_fwd_write), 32'd0);
        check("fw_empty_valid", 32'(s_out_valid), 32'd0);

        // PLAIN mode: replace the head with no bubble
        check("pl_ready_empty", 32'(p_in_ready), 32'd1);
        p_in_valid = 1'b1; p_in_data = 32'h10;
        tick();
        check("pl_head", p_out_data, 32'h10);
        check("pl_ready_blocked", 32'(p_in_ready), 32'd0);
        p_out_ready = 1'b1; p_in_data = 32'h20;
        #1;
        check("pl_ready_comb", 32'(p_in_ready), 32'd1);
        tick();
        check("pl_replace_valid", 32'(p_out_valid), 32'd1);
        check("pl_replace_data", p_out_data, 32'h20);
        p_in_valid = 1'b0;
        tick();
        check("pl_drained", 32'(p_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
